uart_rx_fsm: RTL and testbench

Frame-sequencing controller for the UART receive path. Drives the enable of the shared bit/edge counter and strobes the data sampler, deserializer and the start/parity/stop checkers at the correct oversample edges. Produces data_valid and error flags per frame. Sits between the RX line/checkers and the output register of UART_RX.

---
 rtl/uart_rx_pkg.sv | 28 ++
 rtl/uart_rx_if.sv | 44 ++++
 rtl/uart_rx_edge_decode.sv | 16 +
 rtl/uart_rx_fsm.sv | 138 +++++++++++++
 tb/tb_uart_rx_fsm.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame sequencer.
package uart_rx_pkg;

  localparam int DATA_W     = 8;
  localparam int PRESCALE_W = 5;
  localparam int BIT_CNT_W  = 4;
  localparam int EDGE_CNT_W = 3;

  localparam logic [PRESCALE_W-1:0] PRESCALE_4 = 5'd4;
  localparam logic [PRESCALE_W-1:0] PRESCALE_8 = 5'd8;

  localparam int START_IDX = 0;
  localparam int PAR_IDX   = DATA_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_DONE   = 3'd5
  } rx_state_e;

  function automatic logic prescale_legal(input logic [PRESCALE_W-1:0] ps);
    return (ps == PRESCALE_4) || (ps == PRESCALE_8);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Bundle between the frame sequencer and the RX line, counter, sampler and checkers.
interface uart_rx_if;
  import uart_rx_pkg::*;

  logic                    RX_IN;
  logic                    PAR_EN;
  logic                    PAR_TYP;
  logic [PRESCALE_W-1:0]   prescale;
  logic [BIT_CNT_W-1:0]    bit_cnt;
  logic [EDGE_CNT_W-1:0]   edge_cnt;
  logic                    sampled_bit;
  logic                    strt_glitch;
  logic                    par_err;
  logic                    stp_err;

  logic                    cnt_enable;
  logic                    dat_samp_en;
  logic                    deser_en;
  logic                    strt_chk_en;
  logic                    par_chk_en;
  logic                    stp_chk_en;
  logic                    par_typ_q;
  logic                    data_valid;
  logic                    par_err_flag;
  logic                    frm_err_flag;
  logic                    break_det;

  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP, prescale, bit_cnt, edge_cnt,
           sampled_bit, strt_glitch, par_err, stp_err,
    output cnt_enable, dat_samp_en, deser_en, strt_chk_en, par_chk_en,
           stp_chk_en, par_typ_q, data_valid, par_err_flag, frm_err_flag,
           break_det
  );

  modport master (
    output RX_IN, PAR_EN, PAR_TYP, prescale, bit_cnt, edge_cnt,
           sampled_bit, strt_glitch, par_err, stp_err,
    input  cnt_enable, dat_samp_en, deser_en, strt_chk_en, par_chk_en,
           stp_chk_en, par_typ_q, data_valid, par_err_flag, frm_err_flag,
           break_det
  );

endinterface

// File: rtl/uart_rx_edge_decode.sv
// Maps the latched oversample ratio to the last edge index of a bit period.
module uart_rx_edge_decode
  import uart_rx_pkg::*;
(
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic [EDGE_CNT_W-1:0] last_edge_o,
  output logic                  legal_o
);

  always_comb begin
    legal_o     = prescale_legal(prescale_i);
    last_edge_o = '0;
    if (legal_o) last_edge_o = EDGE_CNT_W'(prescale_i - PRESCALE_W'(1));
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive frame sequencer: strobes sampler, deserializer and checkers per frame.
// Optional break detection is built when UART_RX_BREAK_DET_EN is defined.
//
//   state  | meaning
//   IDLE   | line idle, waiting for a low level with a legal prescale
//   START  | start bit; start checker strobed at bit end
//   DATA   | DATA_W data bits; deserializer strobed at each bit end
//   PARITY | parity bit (only when latched PAR_EN)
//   STOP   | stop bit; frame checker strobed at bit end
//   DONE   | one cycle; data_valid decided, next start may follow directly
module uart_rx_fsm
  import uart_rx_pkg::*;
(
  input  logic      CLK,
  input  logic      RST,
  uart_rx_if.slave  rx_if
);

  localparam logic [BIT_CNT_W-1:0] DATA_LAST = BIT_CNT_W'(PAR_IDX - 1);

  rx_state_e             state_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic [PRESCALE_W-1:0] prescale_q;
  logic                  par_flag_q;
  logic                  frm_flag_q;
  logic                  data_valid_q;

  logic [EDGE_CNT_W-1:0] last_edge;
  logic                  prescale_ok_q;
  logic                  cnt_en;
  logic                  bit_end;
  logic                  start_req;
  logic                  enter_start;

  uart_rx_edge_decode u_edge_decode (
    .prescale_i  (prescale_q),
    .last_edge_o (last_edge),
    .legal_o     (prescale_ok_q)
  );

  always_comb begin
    cnt_en      = (state_q == ST_START) || (state_q == ST_DATA) ||
                  (state_q == ST_PARITY) || (state_q == ST_STOP);
    bit_end     = cnt_en && prescale_ok_q && (rx_if.edge_cnt == last_edge);
    start_req   = !rx_if.RX_IN && prescale_legal(rx_if.prescale);
    enter_start = start_req && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  end

  always_comb begin
    rx_if.cnt_enable  = cnt_en;
    rx_if.dat_samp_en = (state_q == ST_START) || (state_q == ST_DATA);
    rx_if.strt_chk_en = (state_q == ST_START)  && bit_end;
    rx_if.deser_en    = (state_q == ST_DATA)   && bit_end;
    rx_if.par_chk_en  = (state_q == ST_PARITY) && bit_end;
    rx_if.stp_chk_en  = (state_q == ST_STOP)   && bit_end;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= ST_IDLE;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      prescale_q   <= '0;
      par_flag_q   <= 1'b0;
      frm_flag_q   <= 1'b0;
      data_valid_q <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      // Config is sampled only here, so mid-frame changes wait for the next frame.
      if (enter_start) begin
        par_en_q   <= rx_if.PAR_EN;
        par_typ_q  <= rx_if.PAR_TYP;
        prescale_q <= rx_if.prescale;
        par_flag_q <= 1'b0;
        frm_flag_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (start_req) state_q <= ST_START;
        end
        ST_START: begin
          if (bit_end) state_q <= rx_if.strt_glitch ? ST_IDLE : ST_DATA;
        end
        ST_DATA: begin
          if (bit_end && (rx_if.bit_cnt == DATA_LAST))
            state_q <= par_en_q ? ST_PARITY : ST_STOP;
        end
        ST_PARITY: begin
          if (bit_end) begin
            if (rx_if.par_err) par_flag_q <= 1'b1;
            state_q <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if (rx_if.stp_err) frm_flag_q <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          data_valid_q <= !par_flag_q && !frm_flag_q;
          state_q      <= start_req ? ST_START : ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rx_if.par_typ_q    = par_typ_q;
  assign rx_if.data_valid   = data_valid_q;
  assign rx_if.par_err_flag = par_flag_q;
  assign rx_if.frm_err_flag = frm_flag_q;

`ifdef UART_RX_BREAK_DET_EN
  logic all_zero_q;
  logic break_q;

  // A break is a frame of all-zero data whose stop bit was also low.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      all_zero_q <= 1'b0;
      break_q    <= 1'b0;
    end else begin
      break_q <= (state_q == ST_DONE) && all_zero_q && frm_flag_q;
      if (enter_start)
        all_zero_q <= 1'b1;
      else if (rx_if.deser_en)
        all_zero_q <= all_zero_q && !rx_if.sampled_bit;
    end
  end

  assign rx_if.break_det = break_q;
`else
  assign rx_if.break_det = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm: models the bit/edge counter and line, scoreboards frames.
module tb_uart_rx_fsm;
  import uart_rx_pkg::*;

  typedef struct {
    logic [7:0] data;
    logic       pen;
    logic       pflag;
    logic       fflag;
    logic       dv;
    logic       brk;
  } exp_t;

  logic CLK;
  logic RST;

  uart_rx_if u_if ();

  uart_rx_fsm dut (
    .CLK   (CLK),
    .RST   (RST),
    .rx_if (u_if)
  );

  int n_cmp = 0;
  int n_bad = 0;

  exp_t sb_q[$];

  logic [3:0] bc;
  logic [2:0] ec;
  logic [2:0] tb_last;
  logic [7:0] cur_data;
  logic       cur_glitch;
  logic       cur_perr;
  logic       cur_serr;

  int         dcnt;
  logic [7:0] byte_acc;
  int         stage;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Shared bit/edge counter model: clears while disabled, wraps edge at last edge.
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bc <= '0;
      ec <= '0;
    end else if (!u_if.cnt_enable) begin
      bc <= '0;
      ec <= '0;
    end else if (ec == tb_last) begin
      ec <= '0;
      bc <= bc + 4'd1;
    end else begin
      ec <= ec + 3'd1;
    end
  end

  assign u_if.bit_cnt     = bc;
  assign u_if.edge_cnt    = ec;
  assign u_if.sampled_bit = (bc >= 4'd1 && bc <= 4'd8) ? cur_data[3'(bc - 4'd1)] : 1'b1;
  assign u_if.strt_glitch = cur_glitch;
  assign u_if.par_err     = cur_perr;
  assign u_if.stp_err     = cur_serr;

  // Output monitor and scoreboard compare.
  always @(negedge CLK) begin
    if (!RST) begin
      stage = 0;
    end else begin
      if (stage == 2) begin
        chk("data_valid", u_if.data_valid, sb_q[0].dv);
        chk("break_det", u_if.break_det, sb_q[0].brk);
        void'(sb_q.pop_front());
        stage = 0;
      end else if (stage == 1) begin
        chk("par_err_flag", u_if.par_err_flag, sb_q[0].pflag);
        chk("frm_err_flag", u_if.frm_err_flag, sb_q[0].fflag);
        stage = 2;
      end else if (u_if.data_valid || u_if.break_det) begin
        chk("dv_spurious", {u_if.data_valid, u_if.break_det}, 2'b00);
      end
      if (u_if.strt_chk_en) chk("strt_bit", bc, START_IDX);
      if (u_if.par_chk_en) chk("par_bit", bc, PAR_IDX);
      if (u_if.deser_en) begin
        chk("deser_edge", ec, tb_last);
        byte_acc = {u_if.sampled_bit, byte_acc[7:1]};
        dcnt++;
      end
      if (u_if.stp_chk_en) begin
        chk("sb_nonempty", sb_q.size() != 0, 1'b1);
        if (sb_q.size() != 0) begin
          chk("stp_bit", bc, PAR_IDX + int'(sb_q[0].pen));
          chk("deser_cnt", dcnt, 8);
          chk("byte", byte_acc, sb_q[0].data);
          stage = 1;
        end
      end
      if (u_if.dat_samp_en && bc == 4'd0 && ec == 3'd0) begin
        dcnt     = 0;
        byte_acc = '0;
      end
    end
  end

  task automatic wait_cnt_en(input string tag);
    int n = 0;
    while (!u_if.cnt_enable && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk(tag, u_if.cnt_enable, 1'b1);
  endtask

  task automatic wait_stp();
    int n = 0;
    while (!u_if.stp_chk_en && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk("stp_seen", u_if.stp_chk_en, 1'b1);
  endtask

  task automatic wait_bit(input logic [3:0] b);
    int n = 0;
    while (!(u_if.dat_samp_en && bc == b) && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk("bit_reached", bc, b);
  endtask

  task automatic drive_frame(input logic [4:0] ps, input logic pen, input logic ptyp,
                             input logic [7:0] d, input logic perr, input logic serr,
                             input bit b2b, input bit flip);
    exp_t e;
    e.data  = d;
    e.pen   = pen;
    e.pflag = pen & perr;
    e.fflag = serr;
    e.dv    = !(pen & perr) && !serr;
`ifdef UART_RX_BREAK_DET_EN
    e.brk   = (d == 8'h00) && serr;
`else
    e.brk   = 1'b0;
`endif
    u_if.prescale = ps;
    u_if.PAR_EN   = pen;
    u_if.PAR_TYP  = ptyp;
    if (b2b) begin
      // Called on the stop-bit-end negedge of the previous frame.
      u_if.RX_IN = 1'b0;
      @(negedge CLK);
      cur_data = d; cur_perr = perr; cur_serr = serr; cur_glitch = 1'b0;
      tb_last  = 3'(ps - 5'd1);
      sb_q.push_back(e);
      @(negedge CLK);
      chk("b2b_start", u_if.cnt_enable, 1'b1);
    end else begin
      cur_data = d; cur_perr = perr; cur_serr = serr; cur_glitch = 1'b0;
      tb_last  = 3'(ps - 5'd1);
      sb_q.push_back(e);
      u_if.RX_IN = 1'b0;
      wait_cnt_en("start_seen");
    end
    u_if.RX_IN = 1'b1;
    chk("ptyp_latch", u_if.par_typ_q, ptyp);
    if (flip) begin
      wait_bit(4'd3);
      u_if.PAR_TYP = ~ptyp;
      u_if.PAR_EN  = ~pen;
      @(negedge CLK);
      chk("ptyp_hold", u_if.par_typ_q, ptyp);
    end
    wait_stp();
  endtask

  initial begin
    logic seen;
    RST = 1'b0;
    u_if.RX_IN = 1'b1; u_if.PAR_EN = 1'b0; u_if.PAR_TYP = 1'b0; u_if.prescale = 5'd8;
    cur_data = '0; cur_glitch = 1'b0; cur_perr = 1'b0; cur_serr = 1'b0;
    tb_last = 3'd7; dcnt = 0; byte_acc = '0; stage = 0;
    repeat (3) @(negedge CLK);
    chk("rst_cnt_enable", u_if.cnt_enable, 1'b0);
    chk("rst_data_valid", u_if.data_valid, 1'b0);
    chk("rst_flags", {u_if.par_err_flag, u_if.frm_err_flag}, 2'b00);
    chk("rst_break", u_if.break_det, 1'b0);
    chk("rst_par_typ", u_if.par_typ_q, 1'b0);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    drive_frame(5'd8, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge CLK);

    drive_frame(5'd4, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge CLK);
    chk("par_flag_sticky", u_if.par_err_flag, 1'b1);

    // Start-bit glitch
    u_if.prescale = 5'd4; tb_last = 3'd3; cur_glitch = 1'b1;
    u_if.RX_IN = 1'b0;
    repeat (2) @(negedge CLK);
    u_if.RX_IN = 1'b1;
    begin
      int n = 0;
      while (!u_if.strt_chk_en && n < 50) begin
        @(negedge CLK);
        n++;
      end
    end
    chk("glitch_strt_seen", u_if.strt_chk_en, 1'b1);
    @(negedge CLK);
    chk("glitch_idle", u_if.cnt_enable, 1'b0);
    repeat (10) @(negedge CLK);
    chk("glitch_deser", dcnt, 0);
    chk("glitch_flags", {u_if.par_err_flag, u_if.frm_err_flag}, 2'b00);
    cur_glitch = 1'b0;

    // Illegal prescale
    u_if.prescale = 5'd5;
    u_if.RX_IN = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge CLK);
      seen = seen | u_if.cnt_enable;
    end
    chk("ps5_cnt_en", seen, 1'b0);
    u_if.RX_IN = 1'b1;
    repeat (2) @(negedge CLK);

    // Back-to-back frames, config flipped mid-frame 1
    drive_frame(5'd8, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
    drive_frame(5'd8, 1'b1, 1'b1, 8'h96, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (4) @(negedge CLK);

    // All-zero data with a low stop bit
    drive_frame(5'd8, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge CLK);

    // Reset in the middle of DATA
    u_if.prescale = 5'd8; u_if.PAR_EN = 1'b0; u_if.PAR_TYP = 1'b1;
    tb_last = 3'd7; cur_data = 8'hFF; cur_serr = 1'b0;
    u_if.RX_IN = 1'b0;
    wait_cnt_en("rst_frame_start");
    u_if.RX_IN = 1'b1;
    wait_bit(4'd4);
    chk("pre_rst_par_typ", u_if.par_typ_q, 1'b1);
    RST = 1'b0;
    #1;
    chk("mid_rst_cnt_en", u_if.cnt_enable, 1'b0);
    chk("mid_rst_samp", u_if.dat_samp_en, 1'b0);
    chk("mid_rst_deser", u_if.deser_en, 1'b0);
    chk("mid_rst_par_typ", u_if.par_typ_q, 1'b0);
    chk("mid_rst_dv", u_if.data_valid, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("post_rst_idle", u_if.cnt_enable, 1'b0);

    chk("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
